// File: rtl/player_action_fsm_if.sv
// Per-player control bundle: frame strobe, debounced buttons and hit reports in,
// registered action state and sprite index out.
interface player_action_fsm_if #(
   parameter int INPUT_DEPTH        = 5,
   parameter int STATE_DEPTH        = 3,
   parameter int SPRITE_INDEX_DEPTH = 4
);
   logic                          frame_tick;
   logic [INPUT_DEPTH-1:0]        player_buttons;
   logic                          player_attack_connected;
   logic                          opponent_attack_connected;
   logic                          round_restart;
   logic [STATE_DEPTH-1:0]        state;
   logic [SPRITE_INDEX_DEPTH-1:0] sprite_index;
   logic                          actionable;
   logic                          state_changed;
   logic                          action_done;

   modport master (
      output frame_tick, player_buttons, player_attack_connected,
             opponent_attack_connected, round_restart,
      input  state, sprite_index, actionable, state_changed, action_done
   );

   modport slave (
      input  frame_tick, player_buttons, player_attack_connected,
             opponent_attack_connected, round_restart,
      output state, sprite_index, actionable, state_changed, action_done
   );
endinterface

// File: rtl/player_action_fsm.sv
// Player action state machine: per-frame state/sprite advance with press buffering,
// block-stun and sticky WIN/LOSE until a round restart.
module player_action_fsm #(
   parameter int INPUT_DEPTH        = 5,
   parameter int STATE_DEPTH        = 3,
   parameter int SPRITE_INDEX_DEPTH = 4,
   parameter int KICK_FRAMES        = 6,
   parameter int GRAB_FRAMES        = 5,
   parameter int F_WALK_FRAMES      = 4,
   parameter int B_WALK_FRAMES      = 4,
   parameter int BUFFER_FRAMES      = 3,
   parameter int BLOCK_STUN_FRAMES  = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   player_action_fsm_if.slave pif
);
   localparam int SD = STATE_DEPTH;
   localparam int SW = SPRITE_INDEX_DEPTH;
   localparam int BW = $clog2(BUFFER_FRAMES + 1);
   localparam int TW = $clog2(BLOCK_STUN_FRAMES + 1);

   localparam int BIT_K  = 0;
   localparam int BIT_B  = 1;
   localparam int BIT_G  = 2;
   localparam int BIT_WB = 3;
   localparam int BIT_WF = 4;

   localparam logic [SW-1:0] KICK_LAST  = SW'(KICK_FRAMES - 1);
   localparam logic [SW-1:0] GRAB_LAST  = SW'(GRAB_FRAMES - 1);
   localparam logic [SW-1:0] F_LAST     = SW'(F_WALK_FRAMES - 1);
   localparam logic [SW-1:0] B_LAST     = SW'(B_WALK_FRAMES - 1);
   localparam logic [SW-1:0] SPRITE_MAX = {SW{1'b1}};
   localparam logic [BW-1:0] BUF_LOAD   = BW'(BUFFER_FRAMES);
   localparam logic [TW-1:0] STUN_LOAD  = TW'(BLOCK_STUN_FRAMES);

   typedef enum logic [SD-1:0] {
      ST_NOTHING = SD'(0),
      ST_WALK_F  = SD'(1),
      ST_WALK_B  = SD'(2),
      ST_BLOCK   = SD'(3),
      ST_KICK    = SD'(4),
      ST_GRAB    = SD'(5),
      ST_WIN     = SD'(6),
      ST_LOSE    = SD'(7)
   } state_e;

   state_e            state_q, state_d;
   logic [SW-1:0]     sprite_q, sprite_d;
   logic [TW-1:0]     stun_q, stun_d;
   logic              buf_valid_q, buf_valid_d;
   logic              buf_kick_q, buf_kick_d;
   logic [BW-1:0]     buf_cnt_q, buf_cnt_d;
   logic              pend_win_q, pend_win_d;
   logic              pend_lose_q, pend_lose_d;
   logic [1:0]        btn_prev_q, btn_prev_d;
   logic              changed_q, changed_d;
   logic              done_q, done_d;

   logic                   actionable_s;
   logic                   terminal_s;
   logic                   is_walk_s;
   logic                   capture_s;
   logic                   rise_k_s;
   logic                   rise_g_s;
   logic [INPUT_DEPTH-1:0] cand_s;
   state_e                 chosen_s;
   logic [SW-1:0]          walk_last_s;
   logic [SW-1:0]          walk_next_s;

   // Actionability decoded from registered state, stun and sprite position
   always_comb begin
      actionable_s = 1'b0;
      case (state_q)
         ST_NOTHING, ST_WALK_F, ST_WALK_B: actionable_s = 1'b1;
         ST_BLOCK:                         actionable_s = (stun_q == '0);
         ST_KICK:                          actionable_s = (sprite_q == KICK_LAST);
         ST_GRAB:                          actionable_s = (sprite_q == GRAB_LAST);
         default:                          actionable_s = 1'b0;
      endcase
   end

   assign terminal_s  = (state_q == ST_WIN) || (state_q == ST_LOSE);
   assign is_walk_s   = (state_q == ST_WALK_F) || (state_q == ST_WALK_B);
   assign rise_k_s    = pif.player_buttons[BIT_K] & ~btn_prev_q[0];
   assign rise_g_s    = pif.player_buttons[BIT_G] & ~btn_prev_q[1];
   assign capture_s   = ~actionable_s & ~terminal_s & (rise_k_s | rise_g_s);
   assign walk_last_s = (state_q == ST_WALK_F) ? F_LAST : B_LAST;
   assign walk_next_s = (sprite_q >= walk_last_s) ? '0 : sprite_q + SW'(1);

   // Candidate selection: live buttons merged with the buffered press, fixed priority
   always_comb begin
      cand_s        = pif.player_buttons;
      cand_s[BIT_K] = pif.player_buttons[BIT_K] | (buf_valid_q & buf_kick_q);
      cand_s[BIT_G] = pif.player_buttons[BIT_G] | (buf_valid_q & ~buf_kick_q);
      if (cand_s[BIT_K])       chosen_s = ST_KICK;
      else if (cand_s[BIT_B])  chosen_s = ST_BLOCK;
      else if (cand_s[BIT_G])  chosen_s = ST_GRAB;
      else if (cand_s[BIT_WB]) chosen_s = ST_WALK_B;
      else if (cand_s[BIT_WF]) chosen_s = ST_WALK_F;
      else                     chosen_s = ST_NOTHING;
   end

   // Next-state: hit latches, press buffer, then per-tick action priority
   always_comb begin
      state_d     = state_q;
      sprite_d    = sprite_q;
      stun_d      = stun_q;
      buf_valid_d = buf_valid_q;
      buf_kick_d  = buf_kick_q;
      buf_cnt_d   = buf_cnt_q;
      pend_win_d  = pend_win_q | pif.player_attack_connected;
      pend_lose_d = pend_lose_q | pif.opponent_attack_connected;
      btn_prev_d  = {pif.player_buttons[BIT_G], pif.player_buttons[BIT_K]};
      changed_d   = 1'b0;
      done_d      = 1'b0;

      if (pif.round_restart) begin
         state_d     = ST_NOTHING;
         sprite_d    = '0;
         stun_d      = '0;
         buf_valid_d = 1'b0;
         buf_kick_d  = 1'b0;
         buf_cnt_d   = '0;
         pend_win_d  = 1'b0;
         pend_lose_d = 1'b0;
         btn_prev_d  = 2'b00;
      end else begin
         // A press during non-actionable frames beats aging on the same tick
         if (capture_s) begin
            buf_valid_d = 1'b1;
            buf_kick_d  = rise_k_s;
            buf_cnt_d   = BUF_LOAD;
         end else if (pif.frame_tick && actionable_s) begin
            buf_valid_d = 1'b0;
            buf_cnt_d   = '0;
         end else if (pif.frame_tick && (buf_cnt_q != '0)) begin
            buf_cnt_d   = buf_cnt_q - BW'(1);
         end else if (pif.frame_tick) begin
            buf_valid_d = 1'b0;
         end else begin
            buf_valid_d = buf_valid_q;
         end

         if (pif.frame_tick) begin
            pend_win_d  = pif.player_attack_connected;
            pend_lose_d = pif.opponent_attack_connected;
            if (terminal_s) begin
               sprite_d = '0;
            end else if (pend_win_q) begin
               state_d  = ST_WIN;
               sprite_d = '0;
               stun_d   = '0;
            end else if (pend_lose_q && (state_q == ST_BLOCK)) begin
               stun_d   = STUN_LOAD;
               sprite_d = '0;
            end else if (pend_lose_q) begin
               state_d  = ST_LOSE;
               sprite_d = '0;
               stun_d   = '0;
            end else if (!actionable_s) begin
               sprite_d = (sprite_q == SPRITE_MAX) ? sprite_q : sprite_q + SW'(1);
               stun_d   = (stun_q == '0) ? stun_q : stun_q - TW'(1);
            end else begin
               state_d  = chosen_s;
               stun_d   = '0;
               sprite_d = ((chosen_s == state_q) && is_walk_s) ? walk_next_s : '0;
            end
            changed_d = (state_d != state_q);
            done_d    = actionable_s && ((state_q == ST_KICK) || (state_q == ST_GRAB));
         end else begin
            changed_d = 1'b0;
            done_d    = 1'b0;
         end
      end
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_NOTHING;
         sprite_q    <= '0;
         stun_q      <= '0;
         buf_valid_q <= 1'b0;
         buf_kick_q  <= 1'b0;
         buf_cnt_q   <= '0;
         pend_win_q  <= 1'b0;
         pend_lose_q <= 1'b0;
         btn_prev_q  <= 2'b00;
         changed_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sprite_q    <= sprite_d;
         stun_q      <= stun_d;
         buf_valid_q <= buf_valid_d;
         buf_kick_q  <= buf_kick_d;
         buf_cnt_q   <= buf_cnt_d;
         pend_win_q  <= pend_win_d;
         pend_lose_q <= pend_lose_d;
         btn_prev_q  <= btn_prev_d;
         changed_q   <= changed_d;
         done_q      <= done_d;
      end
   end

   assign pif.state         = state_q;
   assign pif.sprite_index  = sprite_q;
   assign pif.actionable    = actionable_s;
   assign pif.state_changed = changed_q;
   assign pif.action_done   = done_q;
endmodule

// File: tb/tb_player_action_fsm.sv
// Directed bench for player_action_fsm: hand-computed state/sprite/pulse values
// checked with immediate assertions after each frame tick.
module tb_player_action_fsm;
   logic sys_clk;
   logic sys_rst_n;
   int   n_vec;
   int   n_err;

   localparam logic [4:0] K  = 5'b00001;
   localparam logic [4:0] B  = 5'b00010;
   localparam logic [4:0] G  = 5'b00100;
   localparam logic [4:0] WB = 5'b01000;
   localparam logic [4:0] WF = 5'b10000;

   player_action_fsm_if #(.INPUT_DEPTH(5), .STATE_DEPTH(3), .SPRITE_INDEX_DEPTH(4)) pif ();

   player_action_fsm dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pif       (pif)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_si(input string tag, input logic [7:0] st, input logic [7:0] idx);
      chk({tag, ".state"}, 8'(pif.state), st);
      chk({tag, ".idx"}, 8'(pif.sprite_index), idx);
   endtask

   task automatic chk_pulses(input string tag, input logic chg, input logic done);
      chk({tag, ".changed"}, 8'(pif.state_changed), 8'(chg));
      chk({tag, ".done"}, 8'(pif.action_done), 8'(done));
   endtask

   task automatic tick();
      @(negedge sys_clk);
      pif.frame_tick = 1'b1;
      @(posedge sys_clk);
      #1;
      pif.frame_tick = 1'b0;
   endtask

   task automatic press(input logic [4:0] bits);
      pif.player_buttons = bits;
      @(posedge sys_clk);
      #1;
      pif.player_buttons = 5'b00000;
   endtask

   task automatic hit(input logic win, input logic lose);
      pif.player_attack_connected   = win;
      pif.opponent_attack_connected = lose;
      @(posedge sys_clk);
      #1;
      pif.player_attack_connected   = 1'b0;
      pif.opponent_attack_connected = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      sys_rst_n                     = 1'b0;
      pif.frame_tick                = 1'b0;
      pif.player_buttons            = 5'b00000;
      pif.player_attack_connected   = 1'b0;
      pif.opponent_attack_connected = 1'b0;
      pif.round_restart             = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      #1;
      chk_si("reset", 8'd0, 8'd0);
      chk_pulses("reset", 1'b0, 1'b0);
      chk("reset.actionable", 8'(pif.actionable), 8'd1);

      // Kick entry, then asynchronous reset in the middle of it
      pif.player_buttons = K;
      tick();
      chk_si("kick0", 8'd4, 8'd0);
      chk_pulses("kick0", 1'b1, 1'b0);
      chk("kick0.actionable", 8'(pif.actionable), 8'd0);
      repeat (3) tick();
      chk_si("kick3", 8'd4, 8'd3);
      #2 sys_rst_n = 1'b0;
      #1;
      chk_si("async_rst", 8'd0, 8'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      tick();
      chk_si("rekick0", 8'd4, 8'd0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk_si($sformatf("rekick%0d", i), 8'd4, 8'(i));
      end
      chk("kick_last.actionable", 8'(pif.actionable), 8'd1);
      tick();
      chk_si("kick_repeat", 8'd4, 8'd0);
      chk_pulses("kick_repeat", 1'b0, 1'b1);

      // Buffered grab press at idx 2 survives to the last kick frame
      pif.player_buttons = 5'b00000;
      repeat (2) tick();
      chk_si("buf_kick2", 8'd4, 8'd2);
      press(G);
      repeat (3) tick();
      chk_si("buf_kick5", 8'd4, 8'd5);
      tick();
      chk_si("buf_grab", 8'd5, 8'd0);
      chk_pulses("buf_grab", 1'b1, 1'b1);
      repeat (4) tick();
      chk_si("grab4", 8'd5, 8'd4);
      pif.player_buttons = K;
      tick();
      chk_si("grab_to_kick", 8'd4, 8'd0);
      chk_pulses("grab_to_kick", 1'b1, 1'b1);

      // Press at idx 1 expires before the kick ends
      pif.player_buttons = 5'b00000;
      tick();
      chk_si("exp_kick1", 8'd4, 8'd1);
      press(G);
      repeat (4) tick();
      chk_si("exp_kick5", 8'd4, 8'd5);
      tick();
      chk_si("expired", 8'd0, 8'd0);
      chk_pulses("expired", 1'b1, 1'b1);

      // Forward walk loop, then priority over it
      pif.player_buttons = WF;
      tick();
      chk_si("wf0", 8'd1, 8'd0);
      chk_pulses("wf0", 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk_si($sformatf("wf_loop%0d", i), 8'd1, 8'(i % 4));
      end
      chk_pulses("wf_wrap", 1'b0, 1'b0);
      pif.player_buttons = WF | WB;
      tick();
      chk_si("wb", 8'd2, 8'd0);
      chk_pulses("wb", 1'b1, 1'b0);
      pif.player_buttons = WF | WB | B;
      tick();
      chk_si("block", 8'd3, 8'd0);

      // Block-stun: two ignored ticks, then kick
      hit(1'b0, 1'b1);
      tick();
      chk_si("stun0", 8'd3, 8'd0);
      chk_pulses("stun0", 1'b0, 1'b0);
      chk("stun0.actionable", 8'(pif.actionable), 8'd0);
      pif.player_buttons = K;
      tick();
      chk_si("stun1", 8'd3, 8'd1);
      tick();
      chk_si("stun2", 8'd3, 8'd2);
      tick();
      chk_si("stun_kick", 8'd4, 8'd0);

      // Hit outside block loses, and LOSE is sticky
      pif.player_buttons = 5'b00000;
      repeat (6) tick();
      chk_si("back_nothing", 8'd0, 8'd0);
      hit(1'b0, 1'b1);
      tick();
      chk_si("lose", 8'd7, 8'd0);
      chk_pulses("lose", 1'b1, 1'b0);
      pif.player_buttons = K | B | G | WB | WF;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_si($sformatf("lose_hold%0d", i), 8'd7, 8'd0);
      end
      chk("lose.actionable", 8'(pif.actionable), 8'd0);

      // Restart without tick, simultaneous hits, restart over a tick
      pif.player_buttons = 5'b00000;
      pif.round_restart  = 1'b1;
      @(posedge sys_clk);
      #1;
      pif.round_restart = 1'b0;
      chk_si("restart", 8'd0, 8'd0);
      hit(1'b1, 1'b1);
      tick();
      chk_si("win", 8'd6, 8'd0);
      chk_pulses("win", 1'b1, 1'b0);
      pif.player_buttons = K;
      @(negedge sys_clk);
      pif.frame_tick    = 1'b1;
      pif.round_restart = 1'b1;
      @(posedge sys_clk);
      #1;
      pif.frame_tick    = 1'b0;
      pif.round_restart = 1'b0;
      chk_si("restart_tick", 8'd0, 8'd0);
      chk_pulses("restart_tick", 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
